// File: rtl/mem_access_arbiter.sv
// Two-way fetch/data arbiter and sequencer for the shared data memory port.
// Ports: clk/rst_n; if_* fetch side; d_* load/store side; mem_* memory port; busy.
module mem_access_arbiter #(
  parameter int ADDR_LIMIT = 64,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_store,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic [6:0]  mem_dp_ctrl,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_LW    = 3'b010;

  localparam int SW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [32:0]   LIMIT      = 33'(ADDR_LIMIT);

  state_t       state;
  logic [SW-1:0] starve;
  logic         gnt_fetch;
  logic         gnt_store;
  logic         gnt_fault;

  logic         sel_fetch;
  logic         sel_store;
  logic [2:0]   sel_f3;
  logic [31:0]  sel_addr;
  logic [31:0]  sel_wdata;
  logic         sel_ok;
  logic [31:0]  cap_data;

  // Size, alignment and range check; range uses 33 bits so a
  // request near 0xFFFFFFFF cannot wrap back into the window.
  function automatic logic access_ok(
    input logic        store,
    input logic [2:0]  f3,
    input logic [31:0] addr
  );
    logic [32:0] size;
    logic        f3_ok;
    logic        al_ok;
    logic        rg_ok;
    size  = 33'd4;
    al_ok = 1'b1;
    case (f3[1:0])
      2'd0: size = 33'd1;
      2'd1: begin
        size  = 33'd2;
        al_ok = ~addr[0];
      end
      2'd2: begin
        size  = 33'd4;
        al_ok = (addr[1:0] == 2'b00);
      end
      default: size = 33'd4;
    endcase
    if (store)
      f3_ok = (f3 <= 3'd2);
    else
      f3_ok = (f3 != 3'd3) && (f3 != 3'd6) &&
              (f3 != 3'd7);
    rg_ok = (({1'b0, addr} + size) <= LIMIT);
    return f3_ok && al_ok && rg_ok;
  endfunction

  // Data wins unless fetch has lost STARVE_MAX times in a row.
  always_comb begin
    sel_fetch = if_req && (!d_req || starve == STARVE_TOP);
    sel_store = 1'b0;
    sel_f3    = F3_LW;
    sel_addr  = if_addr;
    sel_wdata = 32'd0;
    if (!sel_fetch) begin
      sel_store = d_store;
      sel_f3    = d_funct3;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end
    sel_ok = access_ok(sel_store, sel_f3, sel_addr);
  end

  assign cap_data = (gnt_store || gnt_fault) ? 32'd0 : mem_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve      <= '0;
      gnt_fetch   <= 1'b0;
      gnt_store   <= 1'b0;
      gnt_fault   <= 1'b0;
      if_ack      <= 1'b0;
      if_rdata    <= 32'd0;
      if_fault    <= 1'b0;
      d_ack       <= 1'b0;
      d_rdata     <= 32'd0;
      d_fault     <= 1'b0;
      mem_dp_ctrl <= 7'd0;
      mem_funct3  <= 3'd0;
      mem_addr    <= 32'd0;
      mem_wr_data <= 32'd0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if_ack      <= 1'b0;
          d_ack       <= 1'b0;
          mem_dp_ctrl <= 7'd0;
          if (if_req || d_req) begin
            gnt_fetch <= sel_fetch;
            gnt_store <= sel_store;
            gnt_fault <= ~sel_ok;
            if (sel_fetch || !if_req)
              starve <= '0;
            else if (starve != STARVE_TOP)
              starve <= starve + SW'(1);
            // Illegal requests never reach the memory.
            if (sel_ok) begin
              mem_dp_ctrl <= sel_store ? OP_STORE : OP_LOAD;
              mem_funct3  <= sel_f3;
              mem_addr    <= sel_addr;
              mem_wr_data <= sel_wdata;
            end
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          mem_dp_ctrl <= 7'd0;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          if (gnt_fetch) begin
            if_ack   <= 1'b1;
            if_rdata <= cap_data;
            if_fault <= gnt_fault;
          end else begin
            d_ack   <= 1'b1;
            d_rdata <= cap_data;
            d_fault <= gnt_fault;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          mem_dp_ctrl <= 7'd0;
          state       <= IDLE;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a byte-wide memory model.
// Memory decodes opcode/funct3 and returns sign/zero-extended load data.
module tb_mem_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_fault;
  logic        d_req;
  logic        d_store;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_fault;
  logic [6:0]  mem_dp_ctrl;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        busy;

  int checks;
  int errors;

  mem_access_arbiter #(
    .ADDR_LIMIT(64),
    .STARVE_MAX(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .if_fault   (if_fault),
    .d_req      (d_req),
    .d_store    (d_store),
    .d_funct3   (d_funct3),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .d_fault    (d_fault),
    .mem_dp_ctrl(mem_dp_ctrl),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:63];

  function automatic logic [31:0] mem_load(
    input logic [2:0] f3, input logic [31:0] a);
    logic [5:0]  i;
    logic [31:0] w;
    i = a[5:0];
    w = {mem[i + 6'd3], mem[i + 6'd2], mem[i + 6'd1], mem[i]};
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_dp_ctrl == 7'h23) begin
      mem[mem_addr[5:0]] <= mem_wr_data[7:0];
      if (mem_funct3 != 3'd0)
        mem[mem_addr[5:0] + 6'd1] <= mem_wr_data[15:8];
      if (mem_funct3 == 3'd2) begin
        mem[mem_addr[5:0] + 6'd2] <= mem_wr_data[23:16];
        mem[mem_addr[5:0] + 6'd3] <= mem_wr_data[31:24];
      end
    end else if (mem_dp_ctrl == 7'h03) begin
      mem_rd_data <= mem_load(mem_funct3, mem_addr);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data access: grant at E0, ack after E2, idle after E3.
  task automatic access(input string tag,
                        input logic st,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] exp_rd,
                        input logic exp_flt);
    logic [6:0] op;
    op = exp_flt ? 7'h00 : (st ? 7'h23 : 7'h03);
    @(negedge clk);
    d_req    = 1'b1;
    d_store  = st;
    d_funct3 = f3;
    d_addr   = a;
    d_wdata  = wd;
    tick();
    chk({tag, ".ctrl0"}, 32'(mem_dp_ctrl), 32'(op));
    chk({tag, ".busy0"}, 32'(busy), 32'd1);
    tick();
    chk({tag, ".ctrl1"}, 32'(mem_dp_ctrl), 32'd0);
    chk({tag, ".ack1"}, 32'(d_ack), 32'd0);
    tick();
    chk({tag, ".ack2"}, 32'(d_ack), 32'd1);
    chk({tag, ".rdata"}, d_rdata, exp_rd);
    chk({tag, ".fault"}, 32'(d_fault), 32'(exp_flt));
    chk({tag, ".ifack"}, 32'(if_ack), 32'd0);
    d_req = 1'b0;
    tick();
    chk({tag, ".ack3"}, 32'(d_ack), 32'd0);
    chk({tag, ".busy3"}, 32'(busy), 32'd0);
  endtask

  logic exp_d [0:7];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem_rd_data = 32'd0;
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = 32'd0;
    d_req    = 1'b0;
    d_store  = 1'b0;
    d_funct3 = 3'd0;
    d_addr   = 32'd0;
    d_wdata  = 32'd0;

    tick();
    tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ctrl", 32'(mem_dp_ctrl), 32'd0);
    chk("rst.dack", 32'(d_ack), 32'd0);
    chk("rst.iack", 32'(if_ack), 32'd0);
    chk("rst.drd", d_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle.busy", 32'(busy), 32'd0);
    chk("idle.ctrl", 32'(mem_dp_ctrl), 32'd0);

    access("sw8", 1'b1, 3'd2, 32'd8, 32'hDEADBEEF, 32'd0, 1'b0);
    access("lw8", 1'b0, 3'd2, 32'd8, 32'd0, 32'hDEADBEEF, 1'b0);
    access("lb11", 1'b0, 3'd0, 32'd11, 32'd0, 32'hFFFFFFDE, 1'b0);
    access("lbu11", 1'b0, 3'd4, 32'd11, 32'd0, 32'h000000DE, 1'b0);
    access("lh10", 1'b0, 3'd1, 32'd10, 32'd0, 32'hFFFFDEAD, 1'b0);
    access("lhu8", 1'b0, 3'd5, 32'd8, 32'd0, 32'h0000BEEF, 1'b0);
    access("sh12", 1'b1, 3'd1, 32'd12, 32'h00001234, 32'd0, 1'b0);
    access("lw12", 1'b0, 3'd2, 32'd12, 32'd0, 32'h00001234, 1'b0);
    access("lw60", 1'b0, 3'd2, 32'd60, 32'd0, 32'h00000000, 1'b0);

    access("f.lw6", 1'b0, 3'd2, 32'd6, 32'd0, 32'd0, 1'b1);
    access("f.sh5", 1'b1, 3'd1, 32'd5, 32'h55, 32'd0, 1'b1);
    access("f.lw62", 1'b0, 3'd2, 32'd62, 32'd0, 32'd0, 1'b1);
    access("f.lwneg", 1'b0, 3'd2, 32'hFFFFFFFE, 32'd0, 32'd0, 1'b1);
    access("f.ld3", 1'b0, 3'd3, 32'd0, 32'd0, 32'd0, 1'b1);
    access("f.sb64", 1'b1, 3'd0, 32'd64, 32'h1, 32'd0, 1'b1);
    access("f.sw4", 1'b1, 3'd4, 32'd16, 32'h1, 32'd0, 1'b1);
    access("lw8b", 1'b0, 3'd2, 32'd8, 32'd0, 32'hDEADBEEF, 1'b0);

    // Held request: re-granted at E3 with no idle gap.
    @(negedge clk);
    d_req    = 1'b1;
    d_store  = 1'b0;
    d_funct3 = 3'd2;
    d_addr   = 32'd8;
    tick();
    tick();
    tick();
    chk("held.ack1", 32'(d_ack), 32'd1);
    chk("held.rd1", d_rdata, 32'hDEADBEEF);
    tick();
    chk("held.regrant", 32'(mem_dp_ctrl), 32'h03);
    chk("held.busy", 32'(busy), 32'd1);
    chk("held.ackoff", 32'(d_ack), 32'd0);
    tick();
    tick();
    chk("held.ack2", 32'(d_ack), 32'd1);
    chk("held.rd2", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0;
    tick();
    chk("held.idle", 32'(busy), 32'd0);

    // Arbitration: both held, fetch forced every fourth grant.
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    if_req   = 1'b1;
    if_addr  = 32'd8;
    d_req    = 1'b1;
    d_store  = 1'b0;
    d_funct3 = 3'd4;
    d_addr   = 32'd11;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("arb%0d.ack0", i),
          32'({if_ack, d_ack}), 32'd0);
      tick();
      tick();
      chk($sformatf("arb%0d.dack", i),
          32'(d_ack), 32'(exp_d[i]));
      chk($sformatf("arb%0d.iack", i),
          32'(if_ack), 32'(!exp_d[i]));
      if (exp_d[i])
        chk($sformatf("arb%0d.drd", i), d_rdata, 32'h000000DE);
      else
        chk($sformatf("arb%0d.ird", i), if_rdata, 32'hDEADBEEF);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    chk("arb.end", 32'({if_ack, d_ack, busy}), 32'd0);
    chk("arb.ifflt", 32'(if_fault), 32'd0);

    // Reset in the ISSUE cycle of a load.
    @(negedge clk);
    d_req    = 1'b1;
    d_store  = 1'b0;
    d_funct3 = 3'd2;
    d_addr   = 32'd8;
    tick();
    chk("mrst.ctrl0", 32'(mem_dp_ctrl), 32'h03);
    @(negedge clk);
    rst_n = 1'b0;
    d_req = 1'b0;
    tick();
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.ctrl", 32'(mem_dp_ctrl), 32'd0);
    chk("mrst.acks", 32'({if_ack, d_ack}), 32'd0);
    chk("mrst.drd", d_rdata, 32'd0);
    chk("mrst.ird", if_rdata, 32'd0);
    chk("mrst.addr", mem_addr, 32'd0);
    chk("mrst.f3", 32'(mem_funct3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("mrst.noack", 32'({if_ack, d_ack, busy}), 32'd0);
    access("post", 1'b0, 3'd2, 32'd8, 32'd0, 32'hDEADBEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
